// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: default widths and FSM state encoding.
package ram_stream_reader_pkg;

  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_stream_reader_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth; simultaneous push and pop leave the count unchanged.
module ram_stream_reader_sync_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic [W-1:0]   push_data_i,
  input  logic           pop_i,
  output logic [W-1:0]   pop_data_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [PTR_W:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Fetches LEN consecutive RAM words from BASE and streams them out over valid/ready,
// absorbing the RAM read latency with a credit-limited output FIFO.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output state_e            state_o
);

  // Stream handshake: a word transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready the presented word and out_last hold steady.

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              iss_vld_q;
  logic              iss_last_q;
  logic              lat_vld_q;
  logic              lat_last_q;

  logic              push_vld;
  logic              push_last;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;

  // The word returned by the RAM is pushed at the end of the cycle it is valid.
  always_comb begin
    push_vld  = iss_vld_q;
    push_last = iss_last_q;
    if (RD_LAT != 0) begin
      push_vld  = lat_vld_q;
      push_last = lat_last_q;
    end
  end

  assign in_flight   = CNT_W'(iss_vld_q) + ((RD_LAT != 0) ? CNT_W'(lat_vld_q) : CNT_W'(0));
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok   = !fifo_full && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign fifo_pop    = out_valid && out_ready;

  ram_stream_reader_sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_vld),
    .push_data_i ({push_last, mem_rdata}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_last_q <= 1'b0;
      lat_vld_q  <= 1'b0;
      lat_last_q <= 1'b0;
    end else begin
      iss_vld_q  <= 1'b0;
      lat_vld_q  <= iss_vld_q;
      lat_last_q <= iss_last_q;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q <= length;
            if (length == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              // First read goes out on the accepting edge; pipe and FIFO are empty here.
              state_q    <= ST_RUN;
              busy_q     <= 1'b1;
              mem_addr_q <= base_addr;
              issued_q   <= LEN_W'(1);
              iss_vld_q  <= 1'b1;
              iss_last_q <= (length == LEN_W'(1));
            end
          end
        end
        ST_RUN: begin
          if (issued_q == len_q) begin
            state_q <= ST_DRAIN;
          end else if (credit_ok) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            issued_q   <= issued_q + LEN_W'(1);
            iss_vld_q  <= 1'b1;
            iss_last_q <= ((issued_q + LEN_W'(1)) == len_q);
          end
        end
        ST_DRAIN: begin
          if (fifo_pop && fifo_head[DATA_W]) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_W-1:0];
  assign out_last  = !fifo_empty && fifo_head[DATA_W];
  assign state_o   = state_q;

endmodule
